flag_cond_unit: RTL and testbench

//  Consumer end of the ALU result/flag interface. Holds the architectural flag register (FLAGS_t from

---
 rtl/flag_cond_unit.sv | 183 ++++++++++++++++++
 tb/tb_flag_cond_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_cond_unit.sv
// Flag register, branch condition evaluator and flag save/restore stack feeding fetch redirects.
// Optional COND_STATS_EN adds saturating taken/not-taken decision counters.
package flag_cond_pkg;
    typedef struct packed {
        logic       CF;
        logic       OF;
        logic       ZF;
        logic       SF;
        logic [3:0] unused;
    } FLAGS_t;
endpackage

// state | meaning
// IDLE  | ready for a branch request
// RESP  | holding a redirect decision until fetch accepts it
module flag_cond_unit
    import flag_cond_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  FLAGS_t          flags_in,
    input  logic            flags_we,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [3:0]      br_cond,
    input  logic [PC_W-1:0] br_pc,
    input  logic [PC_W-1:0] br_target,
    output logic            redir_valid,
    input  logic            redir_ready,
    output logic            redir_taken,
    output logic [PC_W-1:0] redir_pc,
    input  logic            flag_push,
    input  logic            flag_pop,
    output logic            stk_err,
`ifdef COND_STATS_EN
    output logic [31:0]     taken_cnt,
    output logic [31:0]     ntaken_cnt,
`endif
    output FLAGS_t          flags_q
);
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

    typedef enum logic [0:0] {IDLE, RESP} state_t;

    state_t          state_q;
    logic            br_ready_q, redir_valid_q, redir_taken_q, stk_err_q, stk_err_d;
    logic [PC_W-1:0] redir_pc_q;
    FLAGS_t          flags_d, flags_in_m, eff_flags;
    FLAGS_t          stk_q [STACK_DEPTH];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   push_idx, pop_idx;
    logic            push_en, cond_hit;
    logic            unused_in_bits;

    function automatic logic cond_true(input logic [3:0] c, input logic cf, input logic ovf,
                                       input logic zf, input logic sf);
        logic lt;
        lt = sf ^ ovf;
        case (c)
            4'h0:    cond_true = zf;
            4'h1:    cond_true = !zf;
            4'h2:    cond_true = cf;
            4'h3:    cond_true = !cf;
            4'h4:    cond_true = sf;
            4'h5:    cond_true = !sf;
            4'h6:    cond_true = ovf;
            4'h7:    cond_true = !ovf;
            4'h8:    cond_true = !cf && !zf;
            4'h9:    cond_true = cf || zf;
            4'hA:    cond_true = lt;
            4'hB:    cond_true = !lt;
            4'hC:    cond_true = !zf && !lt;
            4'hD:    cond_true = zf || lt;
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    endfunction

    assign unused_in_bits = ^flags_in.unused;
    assign push_idx       = AW'(cnt_q);
    assign pop_idx        = AW'(cnt_q - 1'b1);
    assign cond_hit       = cond_true(br_cond, eff_flags.CF, eff_flags.OF, eff_flags.ZF, eff_flags.SF);

    // A same-cycle ALU write is forwarded to both branch evaluation and push.
    always_comb begin
        flags_in_m        = flags_in;
        flags_in_m.unused = '0;
        eff_flags         = flags_we ? flags_in_m : flags_q;
    end

    always_comb begin
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        stk_err_d = stk_err_q;
        push_en   = 1'b0;
        if (flag_push && !flag_pop) begin
            if (cnt_q == FULL_CNT) begin
                stk_err_d = 1'b1;
            end else begin
                push_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (flag_pop && !flag_push) begin
            if (cnt_q == '0) begin
                stk_err_d = 1'b1;
            end else begin
                cnt_d   = cnt_q - 1'b1;
                flags_d = stk_q[pop_idx];
            end
        end
        if (flags_we) flags_d = flags_in_m;
    end

    always_ff @(posedge clk) begin
        if (push_en) stk_q[push_idx] <= eff_flags;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            br_ready_q    <= 1'b1;
            redir_valid_q <= 1'b0;
            redir_taken_q <= 1'b0;
            redir_pc_q    <= '0;
            flags_q       <= '0;
            cnt_q         <= '0;
            stk_err_q     <= 1'b0;
        end else begin
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            stk_err_q <= stk_err_d;
            case (state_q)
                IDLE: begin
                    if (br_valid) begin
                        redir_taken_q <= cond_hit;
                        redir_pc_q    <= cond_hit ? br_target : br_pc + PC_W'(4);
                        redir_valid_q <= 1'b1;
                        br_ready_q    <= 1'b0;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    if (redir_ready) begin
                        redir_valid_q <= 1'b0;
                        br_ready_q    <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COND_STATS_EN
    logic [31:0] taken_cnt_q, ntaken_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken_cnt_q  <= '0;
            ntaken_cnt_q <= '0;
        end else if (redir_valid_q && redir_ready) begin
            if (redir_taken_q && taken_cnt_q != 32'hFFFF_FFFF)
                taken_cnt_q <= taken_cnt_q + 32'd1;
            if (!redir_taken_q && ntaken_cnt_q != 32'hFFFF_FFFF)
                ntaken_cnt_q <= ntaken_cnt_q + 32'd1;
        end
    end

    assign taken_cnt  = taken_cnt_q;
    assign ntaken_cnt = ntaken_cnt_q;
`endif

    assign br_ready    = br_ready_q;
    assign redir_valid = redir_valid_q;
    assign redir_taken = redir_taken_q;
    assign redir_pc    = redir_pc_q;
    assign stk_err     = stk_err_q;
endmodule

// File: tb/tb_flag_cond_unit.sv
// Scoreboard bench for flag_cond_unit: expected redirects queued at request, checked at response.
module tb_flag_cond_unit;
    import flag_cond_pkg::*;

    localparam int PC_W  = 32;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    FLAGS_t          flags_in;
    logic            flags_we;
    logic            br_valid;
    logic            br_ready;
    logic [3:0]      br_cond;
    logic [PC_W-1:0] br_pc;
    logic [PC_W-1:0] br_target;
    logic            redir_valid;
    logic            redir_ready;
    logic            redir_taken;
    logic [PC_W-1:0] redir_pc;
    logic            flag_push;
    logic            flag_pop;
    logic            stk_err;
    FLAGS_t          flags_q;
`ifdef COND_STATS_EN
    logic [31:0]     taken_cnt, ntaken_cnt;
`endif

    always #5 clk = ~clk;

    flag_cond_unit #(.STACK_DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
        .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond), .br_pc(br_pc),
        .br_target(br_target), .redir_valid(redir_valid), .redir_ready(redir_ready),
        .redir_taken(redir_taken), .redir_pc(redir_pc), .flag_push(flag_push),
        .flag_pop(flag_pop), .stk_err(stk_err),
`ifdef COND_STATS_EN
        .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt),
`endif
        .flags_q(flags_q)
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mstk[$];
    logic [7:0] mflags;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_taken  = 0;
    int         m_ntaken = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic model_cond(input logic [3:0] c, input logic [7:0] f);
        logic cf, ovf, zf, sf;
        cf = f[7]; ovf = f[6]; zf = f[5]; sf = f[4];
        case (c)
            4'h0: return zf;
            4'h1: return !zf;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return sf;
            4'h5: return !sf;
            4'h6: return ovf;
            4'h7: return !ovf;
            4'h8: return !cf && !zf;
            4'h9: return cf || zf;
            4'hA: return sf != ovf;
            4'hB: return sf == ovf;
            4'hC: return !zf && (sf == ovf);
            4'hD: return zf || (sf != ovf);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic we, input logic [7:0] fin);
        logic [7:0]  eff;
        logic        t;
        logic [31:0] npc;
        eff = we ? {fin[7:4], 4'b0} : mflags;
        t   = model_cond(c, eff);
        npc = pc + 32'd4;
        chk("br_ready_idle", br_ready, 1);
        br_valid  = 1'b1;
        br_cond   = c;
        br_pc     = pc;
        br_target = tgt;
        flags_we  = we;
        flags_in  = fin;
        sb.push_back({t, t ? tgt : npc});
        tick;
        br_valid = 1'b0;
        flags_we = 1'b0;
        if (we) mflags = eff;
    endtask

    task automatic recv(input int stall);
        int         waited;
        exp_t       e;
        logic [7:0] r;
        waited = 0;
        while (!redir_valid && waited < 8) begin
            tick;
            waited++;
        end
        chk("redir_latency", waited, 0);
        if (!redir_valid || sb.size() == 0) begin
            chk("redir_present", {redir_valid, 31'd0, 32'(sb.size())}, {1'b1, 63'd1});
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            chk("stall_taken", redir_taken, e.taken);
            chk("stall_pc", redir_pc, e.pc);
            chk("stall_br_ready", br_ready, 0);
            r        = 8'($urandom);
            flags_we = 1'b1;
            flags_in = r;
            mflags   = {r[7:4], 4'b0};
            tick;
            flags_we = 1'b0;
        end
        chk("redir_taken", redir_taken, e.taken);
        chk("redir_pc", redir_pc, e.pc);
        redir_ready = 1'b1;
        if (e.taken) m_taken++; else m_ntaken++;
        tick;
        redir_ready = 1'b0;
        chk("valid_drop", redir_valid, 0);
        chk("br_ready_back", br_ready, 1);
    endtask

    task automatic load_flags(input logic [7:0] v);
        flags_we = 1'b1;
        flags_in = v;
        tick;
        flags_we = 1'b0;
        mflags   = {v[7:4], 4'b0};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]  r;
        logic [31:0] p, t;
        rst_n = 1'b0; flags_in = '0; flags_we = 1'b0; br_valid = 1'b0; br_cond = '0;
        br_pc = '0; br_target = '0; redir_ready = 1'b0; flag_push = 1'b0; flag_pop = 1'b0;
        mflags = '0;
        @(negedge clk);
        tick;
        chk("rst_flags", flags_q, 0);
        chk("rst_br_ready", br_ready, 1);
        chk("rst_redir", {redir_valid, redir_taken, redir_pc}, 0);
        chk("rst_stk_err", stk_err, 0);
        rst_n = 1'b1;
        tick;

        load_flags(8'h20);
        chk("flags_zf", flags_q, 8'h20);
        send(4'h0, 32'h100, 32'h200, 1'b0, 8'h00);
        recv(0);

        send(4'hA, 32'h300, 32'h400, 1'b1, 8'h10);
        recv(0);
        send(4'hB, 32'h500, 32'h600, 1'b1, 8'h10);
        recv(0);

        send(4'hF, 32'hFFFF_FFFC, 32'h10, 1'b0, 8'h00);
        recv(0);

        send(4'h9, 32'h1000, 32'h2000, 1'b0, 8'h00);
        recv(5);

        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 2; k++) begin
                r = 8'($urandom);
                p = $urandom & 32'hFFFF_FFFC;
                t = $urandom & 32'hFFFF_FFFC;
                send(4'(c), p, t, 1'($urandom), r);
                recv(0);
            end
        end

        load_flags(8'hAF);
        chk("flags_mask", flags_q, 8'hA0);

        flag_push = 1'b1; flag_pop = 1'b1;
        tick;
        flag_push = 1'b0; flag_pop = 1'b0;
        chk("pushpop_err", stk_err, 0);
        chk("pushpop_flags", flags_q, 8'hA0);

        load_flags(8'h30);
        flag_push = 1'b1;
        tick;
        flag_push = 1'b0;
        mstk.push_back(8'h30);
        flags_we = 1'b1; flags_in = 8'hC0; flag_pop = 1'b1;
        tick;
        flags_we = 1'b0; flag_pop = 1'b0;
        void'(mstk.pop_back());
        mflags = 8'hC0;
        chk("pop_we_wins", flags_q, 8'hC0);
        chk("pop_we_err", stk_err, 0);

        for (int i = 0; i < DEPTH; i++) begin
            r = 8'({4'(i * 5 + 9), 4'hF});
            flags_we = 1'b1; flags_in = r; flag_push = 1'b1;
            tick;
            flags_we = 1'b0; flag_push = 1'b0;
            mflags = {r[7:4], 4'b0};
            mstk.push_back(mflags);
        end
        chk("full_no_err", stk_err, 0);
        flag_push = 1'b1;
        tick;
        flag_push = 1'b0;
        chk("overflow_err", stk_err, 1);

        load_flags(8'hF0);
        while (mstk.size() > 0) begin
            flag_pop = 1'b1;
            tick;
            flag_pop = 1'b0;
            mflags = mstk.pop_back();
            chk("pop_lifo", flags_q, mflags);
        end
        flag_pop = 1'b1;
        tick;
        flag_pop = 1'b0;
        chk("underflow_flags", flags_q, mflags);
        chk("underflow_err", stk_err, 1);

`ifdef COND_STATS_EN
        chk("taken_cnt", taken_cnt, 32'(m_taken));
        chk("ntaken_cnt", ntaken_cnt, 32'(m_ntaken));
`endif

        send(4'hE, 32'h40, 32'h80, 1'b0, 8'h00);
        chk("resp_valid", redir_valid, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        sb.delete();
        mflags = '0; m_taken = 0; m_ntaken = 0;
        chk("rst_resp_valid", redir_valid, 0);
        chk("rst_resp_ready", br_ready, 1);
        chk("rst_resp_flags", flags_q, 0);
        chk("rst_resp_err", stk_err, 0);
        tick;

        send(4'h1, 32'h700, 32'h800, 1'b0, 8'h00);
        recv(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
